// File: rtl/dsp_mac_sequencer.sv
// Sequencer for a CE-gated DSP slice (A/B -> M -> P): issues per-stage clock
// enables and OPMODE for a LEN-beat multiply-accumulate burst and flags completion.
module dsp_mac_sequencer #(
  parameter int unsigned    CNT_WIDTH   = 8,
  parameter int unsigned    PIPE_LAT    = 3,
  parameter logic [7:0]     OPMODE_LOAD = 8'h01,
  parameter logic [7:0]     OPMODE_ACC  = 8'h09
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] len,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [PIPE_LAT-1:0]  ce_stage,
  output logic [7:0]           opmode,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PIPE_LAT-2:0]  tok_q, tok_d;
  logic [PIPE_LAT-2:0]  ft_q, ft_d;
  logic                 beat;
  logic                 first;
  logic [PIPE_LAT-1:0]  ce_vec;
  logic [PIPE_LAT-1:0]  ft_vec;

  assign in_ready = (state_q == S_FEED);
  assign beat     = in_valid & in_ready;
  assign first    = beat & (cnt_q == '0);

  // Stage 0 is the live beat; the registered shifters hold stages 1..PIPE_LAT-1.
  assign ce_vec   = {tok_q, beat};
  assign ft_vec   = {ft_q, first};
  assign tok_d    = ce_vec[PIPE_LAT-2:0];
  assign ft_d     = ft_vec[PIPE_LAT-2:0];

  assign ce_stage = ce_vec;
  assign opmode   = (ce_vec[PIPE_LAT-1] && ft_vec[PIPE_LAT-1]) ? OPMODE_LOAD : OPMODE_ACC;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_d   = len;
            cnt_d   = '0;
            state_d = S_FEED;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FEED: begin
        if (beat) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == len_q - CNT_WIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave once the final P enable is the one issuing now.
        if (tok_d == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      tok_q   <= '0;
      ft_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tok_q   <= tok_d;
      ft_q    <= ft_d;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: drives bursts into a behavioural DSP slice and
// checks P against a scoreboard of expected sums, plus CE/OPMODE/done timing.
module tb_dsp_mac_sequencer;

  localparam logic [7:0] LOAD = 8'h01;
  localparam logic [7:0] ACC  = 8'h09;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] len_i = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] ce_stage;
  logic [7:0] opmode;
  logic       busy;
  logic       done;

  dsp_mac_sequencer #(.CNT_WIDTH(8), .PIPE_LAT(3), .OPMODE_LOAD(LOAD), .OPMODE_ACC(ACC)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len_i), .in_valid(in_valid),
    .in_ready(in_ready), .ce_stage(ce_stage), .opmode(opmode), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural slice: A/B regs -> M reg -> P reg, each CE-gated.
  int a_i = 0, b_i = 0;
  int a_r = 0, b_r = 0, m_r = 0, p_r = 0;
  always @(posedge clk) begin
    if (ce_stage[0]) begin a_r <= a_i; b_r <= b_i; end
    if (ce_stage[1]) m_r <= a_r * b_r;
    if (ce_stage[2]) p_r <= (opmode == LOAD) ? m_r : p_r + m_r;
  end

  int total = 0, bad = 0;
  int sb[$];
  int cyc = 0;
  int ce_cnt0, ce_cnt1, ce_cnt2, load_cnt, done_cnt, rdy_cnt, last_beat, done_cyc;
  logic ce_any;
  logic [7:0] first_op;
  int opa[8], opb[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ce_stage[0]) begin ce_cnt0++; last_beat = cyc; end
    if (ce_stage[1]) ce_cnt1++;
    if (ce_stage[2]) begin
      if (ce_cnt2 == 0) first_op = opmode;
      ce_cnt2++;
      if (opmode == LOAD) load_cnt++;
    end
    if (in_ready) rdy_cnt++;
    if (ce_stage != '0) ce_any = 1'b1;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (sb.size() == 0) begin
        total++; bad++;
        $error("FAIL sb_underflow observed=done expected=no_done");
      end else begin
        int e;
        e = sb.pop_front();
        if (e >= 0) check("p_sum", p_r, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_stats();
    ce_cnt0 = 0; ce_cnt1 = 0; ce_cnt2 = 0; load_cnt = 0; done_cnt = 0;
    rdy_cnt = 0; last_beat = 0; done_cyc = 0; ce_any = 1'b0; first_op = '0;
  endtask

  task automatic wait_done(input int maxc);
    int k = 0;
    while (done_cnt == 0 && k < maxc) begin tick(); k++; end
    check("done_seen", done_cnt, 1);
  endtask

  task automatic run_burst(input int n, input int npat, input logic [15:0] vpat,
                           input int exp, input int restart_at);
    int idx = 0;
    clr_stats();
    sb.push_back(exp);
    start = 1'b1; len_i = 8'(n);
    tick();
    start = 1'b0;
    for (int i = 0; i < npat; i++) begin
      in_valid = vpat[i];
      a_i = opa[idx]; b_i = opb[idx];
      if (i == restart_at) begin start = 1'b1; len_i = 8'd7; end
      #1;
      if (vpat[i] && in_ready) idx++;
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    wait_done(20);
    check("ce0_count", ce_cnt0, n);
    check("ce1_count", ce_cnt1, n);
    check("ce2_count", ce_cnt2, n);
    check("load_count", load_cnt, 1);
    check("first_opmode", first_op, LOAD);
    check("latency", done_cyc - last_beat, 3);
  endtask

  initial begin
    clr_stats();
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_ce", ce_stage, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_opmode", opmode, ACC);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Continuous burst of four pairs
    opa = '{1, 3, 5, 7, 0, 0, 0, 0}; opb = '{2, 4, 6, 8, 0, 0, 0, 0};
    run_burst(4, 4, 16'b1111, 100, -1);
    check("rdy_cycles_cont", rdy_cnt, 4);

    // Single operand, then immediate back-to-back reload
    opa[0] = 9; opb[0] = 9;
    run_burst(1, 1, 16'b1, 81, -1);
    opa[0] = 2; opb[0] = 3;
    run_burst(1, 1, 16'b1, 6, -1);

    // Bubbles: valid pattern 1,0,0,1,0,1
    opa = '{2, 3, 4, 0, 0, 0, 0, 0}; opb = '{5, 3, 6, 0, 0, 0, 0, 0};
    run_burst(3, 6, 16'b101001, 43, -1);
    check("rdy_cycles_bubble", rdy_cnt, 6);

    // Zero length
    clr_stats();
    sb.push_back(-1);
    start = 1'b1; len_i = 8'd0;
    tick();
    start = 1'b0;
    check("zl_busy", busy, 1);
    check("zl_done", done, 1);
    tick();
    check("zl_busy_after", busy, 0);
    tick();
    check("zl_done_count", done_cnt, 1);
    check("zl_ce_any", ce_any, 0);
    check("zl_rdy", rdy_cnt, 0);

    // start while busy is ignored
    opa = '{4, 5, 0, 0, 0, 0, 0, 0}; opb = '{1, 2, 0, 0, 0, 0, 0, 0};
    run_burst(2, 2, 16'b11, 14, 0);
    repeat (6) tick();
    check("sb_busy_idle", busy, 0);
    check("sb_beats", ce_cnt0, 2);
    check("sb_rdy", rdy_cnt, 2);
    check("sb_done_count", done_cnt, 1);

    // Async reset mid-FEED
    clr_stats();
    start = 1'b1; len_i = 8'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; a_i = 1; b_i = 1;
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check("ar_busy", busy, 0);
    check("ar_in_ready", in_ready, 0);
    check("ar_ce", ce_stage, 0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check("ar_no_done", done_cnt, 0);
    opa = '{3, 2, 0, 0, 0, 0, 0, 0}; opb = '{7, 2, 0, 0, 0, 0, 0, 0};
    run_burst(2, 2, 16'b11, 25, -1);

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
